// File: rtl/lfsr_scrambler_n.sv
// lfsr_scrambler_n: parametrised Galois LFSR scrambler with a valid/ready
// beat datapath, shadow seed registers with explicit commit, resync input,
// accepted-beat counter and host register readback.
module lfsr_scrambler_n #(
    parameter int                    POLY_WIDTH   = 127,
    parameter logic [POLY_WIDTH-1:0] TAPS         = 127'h0040_2000_0000_0000_2000,
    parameter int                    NUM_OF_STEPS = 16,
    parameter logic [11:0]           BASE_ADDR    = 12'h0cc
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    write,
    input  logic                    read,
    input  logic [11:0]             addr,
    input  logic [31:0]             lfsrdin,
    output logic [31:0]             rdata,
    input  logic                    resync,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_OF_STEPS-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_OF_STEPS-1:0] out_data,
    output logic [POLY_WIDTH-1:0]   dout,
    output logic                    lock_err
);

    localparam int          WORDS      = (POLY_WIDTH + 31) / 32;
    localparam logic [11:0] CTRL_ADDR  = BASE_ADDR + 12'(WORDS);
    localparam logic [11:0] BEATS_ADDR = BASE_ADDR + 12'(WORDS + 1);

    logic [POLY_WIDTH-1:0]   r_state;
    logic [POLY_WIDTH-1:0]   w_seed;
    logic [31:0]             w_seed_rd [WORDS];
    logic                    r_en;
    logic                    r_bypass;
    logic [31:0]             r_beats;
    logic                    r_out_valid;
    logic [NUM_OF_STEPS-1:0] r_out_data;
    logic [31:0]             r_rdata;
    logic [31:0]             w_rd_mux;
    logic [NUM_OF_STEPS-1:0] w_ks;
    logic [POLY_WIDTH-1:0]   w_stage [NUM_OF_STEPS+1];
    logic                    w_accept;
    logic                    w_ctrl_wr;
    logic                    w_beats_wr;
    logic                    w_commit;
    logic                    w_lock;

    assign w_ctrl_wr  = write && (addr == CTRL_ADDR);
    assign w_beats_wr = write && (addr == BEATS_ADDR);
    assign w_commit   = resync | (w_ctrl_wr & lfsrdin[2]);
    assign in_ready   = r_en & (~r_out_valid | out_ready);
    assign w_accept   = in_valid & in_ready;
    assign w_lock     = r_en & (r_state == '0);

    // Shadow seed words; the top word only keeps the bits that exist in the state.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_seed
            localparam int LO = 32 * gi;
            localparam int WK = ((POLY_WIDTH - LO) >= 32) ? 32 : (POLY_WIDTH - LO);
            logic [WK-1:0] r_word;

            // Capture host writes to this seed word.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_word <= '0;
                end else if (write && (addr == BASE_ADDR + 12'(gi))) begin
                    r_word <= lfsrdin[WK-1:0];
                end
            end

            assign w_seed[LO +: WK] = r_word;
            assign w_seed_rd[gi]    = 32'(r_word);
        end
    endgenerate

    // Unrolled keystream: stage j+1 is one Galois step of stage j, all in one cycle.
    assign w_stage[0] = r_state;
    generate
        for (gi = 0; gi < NUM_OF_STEPS; gi++) begin : g_step
            assign w_ks[gi]        = w_stage[gi][POLY_WIDTH-1];
            assign w_stage[gi + 1] = {w_stage[gi][POLY_WIDTH-2:0]
                                      ^ (TAPS[POLY_WIDTH-1:1] & {(POLY_WIDTH-1){w_stage[gi][POLY_WIDTH-1]}}),
                                      w_stage[gi][POLY_WIDTH-1]};
        end
    endgenerate

    // Register read multiplexer; unmapped addresses read as zero.
    always_comb begin
        w_rd_mux = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (addr == BASE_ADDR + 12'(k)) begin
                w_rd_mux = w_seed_rd[k];
            end
        end
        if (addr == CTRL_ADDR) begin
            w_rd_mux = {28'd0, w_lock, 1'b0, r_bypass, r_en};
        end
        if (addr == BEATS_ADDR) begin
            w_rd_mux = r_beats;
        end
    end

    // Control bits; LOAD is not stored, it only produces a commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en     <= 1'b0;
            r_bypass <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_en     <= lfsrdin[0];
            r_bypass <= lfsrdin[1];
        end
    end

    // LFSR state: a commit wins over the advance of a beat accepted in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
        end else if (w_commit) begin
            r_state <= w_seed;
        end else if (w_accept && !r_bypass) begin
            r_state <= w_stage[NUM_OF_STEPS];
        end
    end

    // Output beat register: load on accept, hold under backpressure, drop when taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_bypass ? in_data : (in_data ^ w_ks);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Accepted-beat counter; a host write clears it ahead of any increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beats <= '0;
        end else if (w_beats_wr) begin
            r_beats <= '0;
        end else if (w_accept) begin
            r_beats <= r_beats + 32'd1;
        end
    end

    // Registered read data, holding between reads; sees pre-write values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (read) begin
            r_rdata <= w_rd_mux;
        end
    end

    assign rdata     = r_rdata;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign dout      = r_state;
    assign lock_err  = w_lock;

endmodule
